round_key_mem: RTL

ROUND_KEY_MEM -- requirements
Module: round_key_mem

---
 rtl/round_key_mem_pkg.sv | 16 +
 rtl/round_key_mem_key_ram.sv | 28 ++
 rtl/round_key_mem.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/round_key_mem_pkg.sv
// rtl/round_key_mem_pkg.sv - shared AES key-schedule constants and key store state type
package round_key_mem_pkg;

  // Round-key index / round-count width
  localparam int NB             = 4;
  localparam int NR_128         = 10;
  localparam int NR_256         = 14;
  localparam int ROUND_KEY_BITS = 128;

`ifdef KEY_ZEROIZE_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY, ST_ZEROIZE} key_state_e;
`else
  typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY} key_state_e;
`endif

endpackage

// File: rtl/round_key_mem_key_ram.sv
// rtl/round_key_mem_key_ram.sv - simple dual-port round key array, registered read-first port
module key_ram #(
  parameter int KEY_W = 128,
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [KEY_W-1:0] rdata
);

  logic [KEY_W-1:0] mem [DEPTH];

  // Write port; callers guarantee waddr < DEPTH when we is high
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-edge write lands after the read, so collisions return old data
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/round_key_mem.sv
// rtl/round_key_mem.sv - round key store, 2-cycle pipelined reads; KEY_ZEROIZE_EN adds wipe on reset/rekey
module round_key_mem
  import round_key_mem_pkg::*;
#(
  parameter int KEY_W = ROUND_KEY_BITS,
  parameter int DEPTH = NR_256 + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [NB-1:0]    wr_addr,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             key_load_done,
  input  logic [NB-1:0]    rounds_total,
  input  logic [NB-1:0]    round_key_no,
  input  logic             key_req,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             keys_ready,
  output logic             req_err
);

`ifdef KEY_ZEROIZE_EN
  localparam key_state_e RESET_STATE = ST_ZEROIZE;
`else
  localparam key_state_e RESET_STATE = ST_EMPTY;
`endif

  key_state_e       state_q, state_d;
  logic [NB-1:0]    nr_q, nr_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_oor_q, s1_oor_d;
  logic             s1_err_q, s1_err_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             req_err_q, req_err_d;
  logic             keys_ready_q, keys_ready_d;

  logic             ram_we;
  logic [NB-1:0]    ram_waddr;
  logic [KEY_W-1:0] ram_wdata;
  logic             ram_re;
  logic [KEY_W-1:0] ram_rdata;

  logic             wr_in_range;
  logic             req_ok;
  logic             req_oor;

`ifdef KEY_ZEROIZE_EN
  // Wipe pointer, post-wipe destination, and the write that triggered a rekey wipe
  logic [NB-1:0]    zcnt_q, zcnt_d;
  logic             zdest_q, zdest_d;
  logic             pend_q, pend_d;
  logic [NB-1:0]    pend_addr_q, pend_addr_d;
  logic [KEY_W-1:0] pend_key_q, pend_key_d;
`endif

  assign wr_in_range = wr_en && (int'(wr_addr) < DEPTH);
  // A write in the same cycle takes priority and knocks the schedule out of READY
  assign req_ok      = key_req && (state_q == ST_READY) && !wr_en;
  assign req_oor     = (round_key_no > nr_q) || (int'(round_key_no) >= DEPTH);
  assign ram_re      = req_ok && !req_oor;

  // Schedule state machine and array write-port steering
  always_comb begin
    state_d   = state_q;
    nr_d      = nr_q;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_key;
`ifdef KEY_ZEROIZE_EN
    zcnt_d      = zcnt_q;
    zdest_d     = zdest_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_key_d  = pend_key_q;
    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (wr_en) begin
          state_d     = ST_ZEROIZE;
          zcnt_d      = '0;
          zdest_d     = 1'b1;
          pend_d      = wr_in_range;
          pend_addr_d = wr_addr;
          pend_key_d  = wr_key;
        end
      end
      ST_LOADING: begin
        if (pend_q) begin
          ram_we    = 1'b1;
          ram_waddr = pend_addr_q;
          ram_wdata = pend_key_q;
          pend_d    = 1'b0;
        end else begin
          ram_we = wr_in_range;
        end
        if (key_load_done) begin
          state_d = ST_READY;
          nr_d    = rounds_total;
        end
      end
      ST_ZEROIZE: begin
        ram_we    = 1'b1;
        ram_waddr = zcnt_q;
        ram_wdata = '0;
        zcnt_d    = zcnt_q + 1'b1;
        if (zcnt_q == NB'(DEPTH - 1)) state_d = zdest_q ? ST_LOADING : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
`else
    ram_we = wr_in_range;
    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (wr_en) state_d = ST_LOADING;
      end
      ST_LOADING: begin
        if (key_load_done) begin
          state_d = ST_READY;
          nr_d    = rounds_total;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
`endif
  end

  // Read pipeline: request stage, then output register that holds key between hits
  always_comb begin
    s1_valid_d   = req_ok;
    s1_oor_d     = req_oor;
    s1_err_d     = key_req && (!req_ok || req_oor);
    key_valid_d  = s1_valid_q;
    req_err_d    = s1_err_q;
    key_d        = key_q;
    if (s1_valid_q) key_d = s1_oor_q ? '0 : ram_rdata;
    keys_ready_d = (state_d == ST_READY);
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      nr_q         <= '0;
      s1_valid_q   <= 1'b0;
      s1_oor_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      req_err_q    <= 1'b0;
      keys_ready_q <= 1'b0;
`ifdef KEY_ZEROIZE_EN
      zcnt_q       <= '0;
      zdest_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_key_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      nr_q         <= nr_d;
      s1_valid_q   <= s1_valid_d;
      s1_oor_q     <= s1_oor_d;
      s1_err_q     <= s1_err_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      req_err_q    <= req_err_d;
      keys_ready_q <= keys_ready_d;
`ifdef KEY_ZEROIZE_EN
      zcnt_q       <= zcnt_d;
      zdest_q      <= zdest_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_key_q   <= pend_key_d;
`endif
    end
  end

  key_ram #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH),
    .AW    (NB)
  ) u_key_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (round_key_no),
    .rdata (ram_rdata)
  );

  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign keys_ready = keys_ready_q;
  assign req_err    = req_err_q;

endmodule
